// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: register address map
// and the per-channel output-mode encoding.
package pwm_pkg;

  // Channel shadow duties occupy addresses DUTY_BASE .. DUTY_BASE+NUM_CH-1.
  localparam int DUTY_BASE = 0;

  // Output mode of one channel, derived from its two enable bits.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,  // output forced low
    MODE_ON   = 2'b01,  // output forced high
    MODE_PWM  = 2'b11   // output follows the PWM compare
  } out_mode_e;

  // The prescaler reload register sits directly after the duty block.
  function automatic int presc_addr(input int num_ch);
    return DUTY_BASE + num_ch;
  endfunction

  // en_out has priority: a disabled output is low regardless of en_pwm.
  function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
    if (!en_out) return MODE_OFF;
    if (!en_pwm) return MODE_ON;
    return MODE_PWM;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_channel.sv
// One PWM channel: shadow duty (written by the host), active duty (loaded at
// period wrap), compare against the shared counter, and the output register.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] duty_data,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en_out,
  input  logic             en_pwm,
  output logic             out
);

  logic [CNT_W-1:0] shadow_duty_reg;
  logic [CNT_W-1:0] active_duty_reg;
  logic             out_reg;
  logic             pwm_level;

  // Strict less-than: duty 0 never high, duty 2^CNT_W-1 always high because
  // the counter never reaches its all-ones value.
  assign pwm_level = (cnt < active_duty_reg);
  assign out       = out_reg;

  // Host-visible shadow duty.
  always_ff @(posedge clk) begin
    if (!rst_n)       shadow_duty_reg <= '0;
    else if (duty_we) shadow_duty_reg <= duty_data;
  end

  // Active duty copies the shadow only at wrap; a same-cycle write lands in
  // the shadow and is therefore picked up one period later.
  always_ff @(posedge clk) begin
    if (!rst_n)    active_duty_reg <= '0;
    else if (load) active_duty_reg <= shadow_duty_reg;
  end

  // Registered output according to the current enable mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg <= 1'b0;
    end else begin
      case (out_mode(en_out, en_pwm))
        MODE_OFF: out_reg <= 1'b0;
        MODE_ON:  out_reg <= 1'b1;
        MODE_PWM: out_reg <= pwm_level;
        default:  out_reg <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaler and period counter, write
// decoder, and NUM_CH channel instances.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter  int NUM_CH  = 16,
  parameter  int CNT_W   = 8,
  parameter  int PRESC_W = 8,
  localparam int ADDR_W  = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  // Last counter value before wrap: 2^CNT_W-2 (all ones except the LSB).
  localparam logic [CNT_W-1:0]   CNT_LAST  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt_reg;
  logic [PRESC_W-1:0] presc_reload_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               period_start_reg;
  logic               tick;
  logic               wrap;
  logic               presc_we;
  logic [NUM_CH-1:0]  duty_we;

  // Down-counting prescaler: tick when it reaches zero, then reload. Because
  // the reload value is only consulted at that moment, a new prescaler value
  // takes effect at the next reload without disturbing the period counter.
  assign tick     = (presc_cnt_reg == '0);
  assign wrap     = tick && (cnt_reg == CNT_LAST);
  assign presc_we = wr_en && (wr_addr == ADDR_W'(presc_addr(NUM_CH)));

  assign period_start = period_start_reg;

  // Prescaler count.
  always_ff @(posedge clk) begin
    if (!rst_n)    presc_cnt_reg <= '0;
    else if (tick) presc_cnt_reg <= presc_reload_reg;
    else           presc_cnt_reg <= presc_cnt_reg - PRESC_ONE;
  end

  // Prescaler reload register (low PRESC_W bits of the write data).
  always_ff @(posedge clk) begin
    if (!rst_n)        presc_reload_reg <= '0;
    else if (presc_we) presc_reload_reg <= PRESC_W'(wr_data);
  end

  // Period counter 0 .. 2^CNT_W-2, advancing on ticks only.
  always_ff @(posedge clk) begin
    if (!rst_n)    cnt_reg <= '0;
    else if (tick) cnt_reg <= wrap ? '0 : cnt_reg + CNT_ONE;
  end

  // One-cycle pulse coinciding with the counter returning to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) period_start_reg <= 1'b0;
    else        period_start_reg <= wrap;
  end

  // One channel per output bit, each with its own duty write strobe.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign duty_we[gi] = wr_en && (wr_addr == ADDR_W'(DUTY_BASE + gi));

      pwm_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty_we   (duty_we[gi]),
        .duty_data (wr_data),
        .load      (wrap),
        .cnt       (cnt_reg),
        .en_out    (en_out[gi]),
        .en_pwm    (en_pwm[gi]),
        .out       (out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: cycle scoreboard fed by a
// tick/phase reference model, plus directed duty-cycle window counts.
module tb_pwm_multi_channel;

  localparam int NUM_CH  = 16;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int ADDR_W  = $clog2(NUM_CH + 1);
  localparam int PERIOD  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .out          (out),
    .period_start (period_start)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NUM_CH-1:0] out;
    logic              ps;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: ticks counted since reset; counter position is simply
  // ticks mod PERIOD. wait_cyc = cycles left before the next tick.
  int m_ticks = 0;
  int m_wait  = 0;
  int m_presc = 0;
  int m_shadow[NUM_CH];
  int m_active[NUM_CH];
  int cyc = 0;

  int win_hi[NUM_CH];
  int win_ps;
  int last_wait;

  task automatic model_step();
    exp_t e;
    int   phase;
    e.out = '0;
    e.ps  = 1'b0;
    if (!rst_n) begin
      m_ticks = 0; m_wait = 0; m_presc = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      phase = m_ticks % PERIOD;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en_out[i])      e.out[i] = 1'b0;
        else if (!en_pwm[i]) e.out[i] = 1'b1;
        else                 e.out[i] = (phase < m_active[i]);
      end
      if (m_wait == 0) begin
        m_ticks++;
        m_wait = m_presc;
        if (m_ticks % PERIOD == 0) begin
          e.ps = 1'b1;
          for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
        end
      end else begin
        m_wait--;
      end
      if (wr_en) begin
        if (int'(wr_addr) < NUM_CH) m_shadow[wr_addr] = int'(wr_data);
        else if (int'(wr_addr) == NUM_CH) m_presc = int'(wr_data) & ((1 << PRESC_W) - 1);
      end
    end
    sb_q.push_back(e);
  endtask

  // One clock: predict, let the edge happen, return just after it.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: every edge the DUT presents a new output word; compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (out !== e.out || period_start !== e.ps) begin
          errors++;
          $display("FAIL sb cyc=%0d out got=%h exp=%h ps got=%b exp=%b",
                   cyc, out, e.out, period_start, e.ps);
        end
      end
    end
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = CNT_W'(data);
    step();
    wr_en   = 1'b0;
  endtask

  // Advance until period_start is seen (bounded).
  task automatic wait_ps(input string name);
    bit found = 0;
    last_wait = 0;
    while (!found && last_wait < 5000) begin
      step();
      last_wait++;
      if (period_start) found = 1;
    end
    if (!found) check_eq({name, "_timeout"}, 0, 1);
  endtask

  // Count high samples per channel and period_start pulses over len cycles,
  // optionally issuing one duty write at cycle wr_at.
  task automatic run_window(input int len, input int wr_at, input int wch, input int wval);
    win_ps = 0;
    for (int i = 0; i < NUM_CH; i++) win_hi[i] = 0;
    for (int i = 0; i < len; i++) begin
      if (i == wr_at) begin
        wr_en = 1'b1; wr_addr = ADDR_W'(wch); wr_data = CNT_W'(wval);
      end
      step();
      wr_en = 1'b0;
      for (int c = 0; c < NUM_CH; c++) win_hi[c] += int'(out[c]);
      win_ps += int'(period_start);
    end
  endtask

  initial begin
    int acc3, acc4, cnt;
    rst_n = 1'b0; en_out = '0; en_pwm = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state.
    repeat (3) step();
    check_eq("reset_out", int'(out), 0);
    check_eq("reset_ps", int'(period_start), 0);

    // Forced-high mode after one clock; no period_start before first wrap.
    rst_n = 1'b1; en_out = '1; en_pwm = '0;
    step();
    check_eq("force_high_out", int'(out == '1), 1);
    cnt = 0;
    repeat (100) begin step(); cnt += int'(period_start); end
    check_eq("no_early_ps", cnt, 0);

    // Duty setup: ch0=128, ch1=64, ch3=0, ch4=255, PWM mode everywhere.
    en_pwm = '1;
    wr(0, 128); wr(1, 64); wr(3, 0); wr(4, 255);
    wait_ps("sync1");
    run_window(PERIOD, -1, 0, 0);
    check_eq("ch0_duty128", win_hi[0], 128);
    check_eq("ch1_duty64", win_hi[1], 64);
    check_eq("ps_per_255", win_ps, 1);
    acc3 = win_hi[3]; acc4 = win_hi[4];

    // Mid-period change 64 -> 192: this period stays 64, next is 192.
    run_window(PERIOD, 100, 1, 192);
    check_eq("ch1_midwrite_cur", win_hi[1], 64);
    acc3 += win_hi[3]; acc4 += win_hi[4];
    run_window(PERIOD, -1, 0, 0);
    check_eq("ch1_midwrite_next", win_hi[1], 192);
    acc3 += win_hi[3]; acc4 += win_hi[4];
    check_eq("ch3_duty0_3per", acc3, 0);
    check_eq("ch4_duty255_3per", acc4, 3 * PERIOD);

    // Write coinciding with the wrap: applies one period later.
    run_window(PERIOD, PERIOD - 1, 1, 32);
    check_eq("ch1_wrapwrite_cur", win_hi[1], 192);
    run_window(PERIOD, -1, 0, 0);
    check_eq("ch1_wrapwrite_next", win_hi[1], 192);
    run_window(PERIOD, -1, 0, 0);
    check_eq("ch1_wrapwrite_late", win_hi[1], 32);

    // Prescaler 3: 4-clk ticks, duty 10 -> 40 high of 1020.
    wr(0, 10); wr(NUM_CH, 3);
    wait_ps("sync_p1");
    wait_ps("sync_p2");
    check_eq("presc3_period", last_wait, 4 * PERIOD);
    run_window(4 * PERIOD, -1, 0, 0);
    check_eq("presc3_ch0_hi", win_hi[0], 40);
    check_eq("presc3_ps", win_ps, 1);

    // Write to an unmapped address changes nothing.
    wr(NUM_CH + 1, 77);
    wait_ps("sync_bad");
    run_window(4 * PERIOD, -1, 0, 0);
    check_eq("badaddr_ch0_hi", win_hi[0], 40);
    check_eq("badaddr_ch1_hi", win_hi[1], 4 * 32);
    check_eq("badaddr_ps", win_ps, 1);

    // Reset pulse mid-period with active outputs.
    repeat (300) step();
    rst_n = 1'b0;
    step();
    check_eq("midreset_out", int'(out), 0);
    check_eq("midreset_ps", int'(period_start), 0);
    rst_n = 1'b1;
    wait_ps("sync_after_reset");
    check_eq("first_period_after_reset", last_wait, PERIOD);
    check_eq("duties_cleared_out", int'(out), 0);

    // Randomized traffic, checked cycle-by-cycle by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      int a;
      if ($urandom_range(0, 19) == 0) en_out = NUM_CH'($urandom);
      if ($urandom_range(0, 19) == 0) en_pwm = NUM_CH'($urandom);
      rst_n = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, NUM_CH + 2);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = (a == NUM_CH) ? CNT_W'($urandom_range(0, 3)) : CNT_W'($urandom);
      end
      step();
      wr_en = 1'b0;
    end
    rst_n = 1'b1;

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 16, which sets the number of PWM channels (range 1..32).
REQ-002 The block SHALL take parameter CNT_W, default 8, which sets the width of the duty and period counter (range 4..16).
REQ-003 The block SHALL take parameter PRESC_W, default 8, which sets the width of the prescaler.
REQ-004 The block SHALL have port clk, input, width 1; it is the single clock, and all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, width 1; it is the reset, synchronous and active-low.
REQ-006 The block SHALL have port en_out, input, width NUM_CH; it is the per-channel output enable.
REQ-007 The block SHALL have port en_pwm, input, width NUM_CH; it is the per-channel PWM mode enable.
REQ-008 The block SHALL have port wr_en, input, width 1; it is a single-cycle write strobe.
REQ-009 The block SHALL have port wr_addr, input, width clog2(NUM_CH+1); it selects the target of a write.
REQ-010 The block SHALL have port wr_data, input, width CNT_W; it carries the write data.
REQ-011 The block SHALL have port out, output, width NUM_CH; these are the registered channel outputs.
REQ-012 The block SHALL have port period_start, output, width 1; it is a one-cycle pulse at each counter wrap.

Function
REQ-013 Writes SHALL be decoded as follows: wr_addr 0..NUM_CH-1 writes the shadow duty of that channel; wr_addr NUM_CH writes the prescaler reload value (low PRESC_W bits of wr_data); writes to any other address SHALL be ignored.
REQ-014 The prescaler SHALL generate a tick once every (presc+1) clk cycles; presc=0 SHALL produce a tick on every cycle.
REQ-015 The period counter SHALL advance only on a tick and count 0..2^CNT_W-2, then wrap to 0, giving a period of 2^CNT_W-1 ticks.
REQ-016 On the tick that wraps the counter to 0, period_start SHALL assert for exactly one clk cycle, and every channel's active duty SHALL load from its shadow duty.
REQ-017 If a shadow write and a wrap occur in the same cycle, the active duty SHALL load the pre-write shadow value, and the new value SHALL take effect at the next wrap.
REQ-018 The PWM level of a channel SHALL be 1 when counter < active duty, so duty 0 is always low and duty 2^CNT_W-1 is always high.
REQ-019 Each output bit SHALL take the following value one clk after the inputs: en_out=0 gives 0; en_out=1 with en_pwm=0 gives 1; en_out=1 with en_pwm=1 gives the PWM level.
REQ-020 A prescaler write SHALL take effect at the next prescaler reload and SHALL NOT reset the period counter.
REQ-021 Changes on en_out and en_pwm SHALL take effect one clk later, with no dependence on period alignment.

Reset
REQ-022 While rst_n=0 at a clk edge, the block SHALL clear out, period_start, the counter, the prescaler count, the prescaler reload value, all shadow duties and all active duties to 0.
REQ-023 A reset asserted mid-period SHALL abort the period, and after release the first period SHALL start from counter 0 with all duties 0.
REQ-024 The first tick after reset release SHALL occur (presc+1) cycles after release.

Structure
REQ-025 The address map constants (duty base 0, prescaler address NUM_CH) and the output-mode encoding SHALL live in the shared package pwm_pkg.
REQ-026 A per-channel sub-module pwm_channel, holding the shadow duty, active duty, compare logic and output register, SHALL be instantiated NUM_CH times from a generate loop; the prescaler and counter SHALL be shared in the top level.

Verification
REQ-027 The bench SHALL cover: reset, then en_out=all 1s and en_pwm=0 -> out=all 1s after 1 clk, and period_start stays low until the first wrap.
REQ-028 The bench SHALL cover: CNT_W=8, presc=0, ch0 duty=128, both enables on -> ch0 is high 128 of every 255 cycles, and period_start pulses every 255 cycles.
REQ-029 The bench SHALL cover: ch3 duty=0 and ch4 duty=255 -> ch3 is constant 0 and ch4 is constant 1 across 3 periods.
REQ-030 The bench SHALL cover: ch1 duty changed 64->192 mid-period -> the current period stays at 64 high cycles and the next period has 192 high cycles; a write coinciding with period_start applies one period later.
REQ-031 The bench SHALL cover: presc=3 -> the tick period is 4 clk, and with duty=10 the output is high 40 of 1020 cycles.
REQ-032 The bench SHALL cover: rst_n pulsed low mid-period with active outputs -> out=0 at the next edge, and a write to address NUM_CH+1 leaves all state unchanged.
